bcd_disp_scan: RTL and testbench

BCD_DISP_SCAN -- requirements
Module: bcd_disp_scan

---
 rtl/bcd_disp_pkg.sv | 16 +
 rtl/bcd_to_seg.sv | 23 ++
 rtl/bcd_disp_scan.sv | 69 ++++++
 tb/tb_bcd_disp_scan.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: segment type and 7-segment glyph constants ({g,f,e,d,c,b,a}, active-high)
package bcd_disp_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to 7-segment decoder; codes above 9 show a dash
// Ports: i_bcd (4-bit code), o_seg (segment pattern)
import bcd_disp_pkg::*;
module bcd_to_seg (
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan: multiplexed BCD 7-segment display scanner with digit register file
// Ports: clk, rst (async, active-high), load/digit_sel/bcd_in (digit write),
//        seg (registered segments), an (registered one-hot digit enable), err (sticky bad-code flag)
// Optional: define BCD_DISP_LZB_EN for leading-zero blanking (digit 0 never blanked)
import bcd_disp_pkg::*;
module bcd_disp_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [$clog2(DIGITS)-1:0] digit_sel,
  input  logic [3:0]                bcd_in,
  output seg_t                      seg,
  output logic [DIGITS-1:0]         an,
  output logic                      err
);
  localparam int SW = $clog2(DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [3:0]        r_digits [DIGITS];
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_idx;
  logic [DIGITS-1:0] r_an;
  seg_t              r_seg;
  logic              r_err;
  logic              w_tick;
  logic              w_wr;
  seg_t              w_dec;
  seg_t              w_seg;
  assign w_tick = r_cnt == CW'(REFRESH_DIV - 1);
  // digit_sel may exceed DIGITS-1 when DIGITS is not a power of two
  assign w_wr   = load && (int'(digit_sel) < DIGITS);
  bcd_to_seg u_dec (.i_bcd(r_digits[r_idx]), .o_seg(w_dec));
`ifdef BCD_DISP_LZB_EN
  logic w_blank;
  // blank when the current digit and every digit above it are zero
  always_comb begin
    w_blank = r_idx != '0;
    for (int i = 0; i < DIGITS; i++)
      if (i >= int'(r_idx) && r_digits[i] != 4'd0) w_blank = 1'b0;
  end
  assign w_seg = w_blank ? SEG_BLANK : w_dec;
`else
  assign w_seg = w_dec;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_an  <= '0;
      r_seg <= SEG_BLANK;
      r_err <= 1'b0;
      for (int i = 0; i < DIGITS; i++) r_digits[i] <= 4'd0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= (r_idx == SW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      if (w_wr) begin
        r_digits[digit_sel] <= bcd_in;
        if (bcd_in > 4'd9) r_err <= 1'b1;
      end
      r_an  <= DIGITS'(1) << r_idx;
      r_seg <= w_seg;
    end
  end
  assign an  = r_an;
  assign seg = r_seg;
  assign err = r_err;
endmodule

// File: tb/tb_bcd_disp_scan.sv
// tb_bcd_disp_scan: table-driven and directed checks of bcd_disp_scan (DIGITS=4, REFRESH_DIV=4)
module tb_bcd_disp_scan;
  typedef struct packed {
    logic [3:0][3:0] d;
    logic [3:0][6:0] exp;
    logic            err;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [1:0] digit_sel = '0;
  logic [3:0] bcd_in = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       err;
  int checks = 0;
  int errors = 0;
  vec_t tbl [5];
  bcd_disp_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .digit_sel(digit_sel),
    .bcd_in(bcd_in), .seg(seg), .an(an), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] sel, input logic [3:0] val);
    load = 1'b1;
    digit_sel = sel;
    bcd_in = val;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
  endtask
  initial begin
`ifdef BCD_DISP_LZB_EN
    tbl[0] = '{d: {4'd9, 4'd4, 4'd2, 4'd1}, exp: {7'h6F, 7'h66, 7'h5B, 7'h06}, err: 1'b0};
    tbl[1] = '{d: {4'd7, 4'd5, 4'd3, 4'd0}, exp: {7'h07, 7'h6D, 7'h4F, 7'h3F}, err: 1'b0};
    tbl[2] = '{d: {4'd0, 4'd0, 4'd3, 4'd0}, exp: {7'h00, 7'h00, 7'h4F, 7'h3F}, err: 1'b0};
    tbl[3] = '{d: {4'd0, 4'hA, 4'd6, 4'd8}, exp: {7'h00, 7'h40, 7'h7D, 7'h7F}, err: 1'b1};
    tbl[4] = '{d: {4'd0, 4'd0, 4'd0, 4'd5}, exp: {7'h00, 7'h00, 7'h00, 7'h6D}, err: 1'b1};
`else
    tbl[0] = '{d: {4'd9, 4'd4, 4'd2, 4'd1}, exp: {7'h6F, 7'h66, 7'h5B, 7'h06}, err: 1'b0};
    tbl[1] = '{d: {4'd7, 4'd5, 4'd3, 4'd0}, exp: {7'h07, 7'h6D, 7'h4F, 7'h3F}, err: 1'b0};
    tbl[2] = '{d: {4'd0, 4'd0, 4'd3, 4'd0}, exp: {7'h3F, 7'h3F, 7'h4F, 7'h3F}, err: 1'b0};
    tbl[3] = '{d: {4'd0, 4'hA, 4'd6, 4'd8}, exp: {7'h3F, 7'h40, 7'h7D, 7'h7F}, err: 1'b1};
    tbl[4] = '{d: {4'd0, 4'd0, 4'd0, 4'd5}, exp: {7'h3F, 7'h3F, 7'h3F, 7'h6D}, err: 1'b1};
`endif
    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_an", an, 0);
    chk("rst_seg", seg, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    // free scan with empty register file
    for (int n = 1; n <= 17; n++) begin
      logic [3:0] ea;
      tick();
      ea = 4'b1 << (((n - 1) / 4) % 4);
      chk($sformatf("scan_an_%0d", n), an, ea);
      chk($sformatf("scan_seg_%0d", n), seg, 7'h3F);
    end
    // table vectors: load all digits, then watch one full scan
    for (int v = 0; v < 5; v++) begin
      logic [3:0] seen;
      for (int j = 0; j < 4; j++) wr(2'(j), tbl[v].d[j]);
      tick();
      seen = '0;
      for (int c = 0; c < 16; c++) begin
        int k;
        tick();
        k = -1;
        for (int b = 0; b < 4; b++) if (an == (4'b1 << b)) k = b;
        chk($sformatf("v%0d_an_onehot", v), 32'($onehot(an)), 1);
        if (k >= 0) chk($sformatf("v%0d_seg_d%0d", v, k), seg, tbl[v].exp[k]);
        chk($sformatf("v%0d_err", v), err, tbl[v].err);
        seen |= an;
      end
      chk($sformatf("v%0d_all_digits", v), seen, 4'hF);
    end
    // async reset mid-scan during a write: immediate clear, write lost
    load = 1'b1;
    digit_sel = 2'd2;
    bcd_in = 4'd8;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_an", an, 0);
    chk("mid_rst_seg", seg, 0);
    chk("mid_rst_err", err, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    tick();
    chk("post_rst_an", an, 1);
    chk("post_rst_seg", seg, 7'h3F);
    chk("post_rst_err", err, 0);
    begin
      bit got = 0;
      for (int c = 0; c < 16 && !got; c++) begin
        tick();
        if (an == 4'd4) begin
          got = 1;
          chk("lost_write_seg", seg, 7'h3F);
        end
      end
      if (!got) chk("lost_write_timeout", 0, 1);
    end
    // write to the displayed digit shows one cycle later
    begin
      bit got = 0;
      logic [3:0] prev;
      for (int c = 0; c < 40 && !got; c++) begin
        prev = an;
        tick();
        if (prev == 4'd8 && an == 4'd1) got = 1;
      end
      if (!got) chk("live_write_timeout", 0, 1);
      else begin
        wr(2'd0, 4'd7);
        chk("live_write_before", seg, 7'h3F);
        tick();
        chk("live_write_an", an, 1);
        chk("live_write_seg", seg, 7'h07);
      end
    end
    // invalid code: sticky err and dash
    chk("err_clear_before", err, 0);
    wr(2'd1, 4'b1010);
    chk("err_set", err, 1);
    begin
      bit got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        if (an == 4'd2) begin
          got = 1;
          chk("dash_seg", seg, 7'h40);
        end
      end
      if (!got) chk("dash_timeout", 0, 1);
    end
    wr(2'd2, 4'd3);
    wr(2'd1, 4'd4);
    chk("err_sticky", err, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
